// File: rtl/flow_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flow_uart_tx_pkg
//  Purpose  : Shared constants for the segment-flow display path: the
//             active-low 7-segment codes (shared with the flow shifter so
//             encode and decode stay in lockstep), ASCII constants and the
//             transmitter FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package flow_uart_tx_pkg;

   // Active-low 7-segment codes, one per hex digit
   localparam logic [7:0] SEG_0     = 8'h03;
   localparam logic [7:0] SEG_1     = 8'h9F;
   localparam logic [7:0] SEG_2     = 8'h25;
   localparam logic [7:0] SEG_3     = 8'h0D;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h49;
   localparam logic [7:0] SEG_6     = 8'h41;
   localparam logic [7:0] SEG_7     = 8'h1F;
   localparam logic [7:0] SEG_8     = 8'h01;
   localparam logic [7:0] SEG_9     = 8'h19;
   localparam logic [7:0] SEG_A     = 8'h11;
   localparam logic [7:0] SEG_B     = 8'hC1;
   localparam logic [7:0] SEG_C     = 8'hE5;
   localparam logic [7:0] SEG_D     = 8'h85;
   localparam logic [7:0] SEG_E     = 8'h61;
   localparam logic [7:0] SEG_F     = 8'h71;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/flow_uart_tx_seg_to_ascii.sv
`default_nettype none
// ============================================================================
//  Module   : seg_to_ascii
//  Purpose  : Combinational decode of one active-low 7-segment code back to
//             its ASCII hex character. Blank maps to space, anything
//             unrecognised maps to '?'.
//  Ports    : seg   [7:0] in  - segment code
//             ascii [7:0] out - ASCII character
//  Revision : 1.0 - initial release
// ============================================================================
module seg_to_ascii
   import flow_uart_tx_pkg::*;
(
   input  logic [7:0] seg,
   output logic [7:0] ascii
);

   always_comb begin
      case (seg)
         SEG_0:     ascii = 8'h30;
         SEG_1:     ascii = 8'h31;
         SEG_2:     ascii = 8'h32;
         SEG_3:     ascii = 8'h33;
         SEG_4:     ascii = 8'h34;
         SEG_5:     ascii = 8'h35;
         SEG_6:     ascii = 8'h36;
         SEG_7:     ascii = 8'h37;
         SEG_8:     ascii = 8'h38;
         SEG_9:     ascii = 8'h39;
         SEG_A:     ascii = 8'h41;
         SEG_B:     ascii = 8'h42;
         SEG_C:     ascii = 8'h43;
         SEG_D:     ascii = 8'h44;
         SEG_E:     ascii = 8'h45;
         SEG_F:     ascii = 8'h46;
         SEG_BLANK: ascii = ASCII_SPACE;
         default:   ascii = ASCII_QMARK;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/flow_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : flow_uart_tx
//  Purpose  : Echo transmitter. On start, snapshots the six-digit segment
//             flow, decodes each digit to ASCII and sends it over an 8N1
//             UART line, optionally followed by CR/LF.
//  Ports    : clk          in  - system clock
//             rst          in  - synchronous active-high reset
//             start        in  - single-cycle transmit request (IDLE only)
//             display_flow in  - six segment codes, [47:40] oldest
//             tx           out - serial line, idles high (registered)
//             busy         out - transmission in progress
//             done         out - one-cycle pulse as busy falls
//  Revision : 1.0 - initial release
// ============================================================================
module flow_uart_tx
   import flow_uart_tx_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 9600,
   parameter bit SEND_CRLF = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [47:0] display_flow,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int              BAUD_DIV  = CLK_FREQ / BAUD_RATE;
   localparam int              CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [2:0]      LAST_BYTE = SEND_CRLF ? 3'd7 : 3'd5;

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [2:0]       byte_idx;
   logic [47:0]      snapshot;
   logic [7:0]       shift_reg;

   logic [7:0]       sel_seg;
   logic [7:0]       dec_char;
   logic [7:0]       cur_char;

   // Digit 0 is the oldest (most significant) byte of the snapshot
   always_comb begin
      case (byte_idx)
         3'd0:    sel_seg = snapshot[47:40];
         3'd1:    sel_seg = snapshot[39:32];
         3'd2:    sel_seg = snapshot[31:24];
         3'd3:    sel_seg = snapshot[23:16];
         3'd4:    sel_seg = snapshot[15:8];
         default: sel_seg = snapshot[7:0];
      endcase
   end

   seg_to_ascii u_seg_to_ascii (
      .seg   (sel_seg),
      .ascii (dec_char)
   );

   always_comb begin
      case (byte_idx)
         3'd6:    cur_char = ASCII_CR;
         3'd7:    cur_char = ASCII_LF;
         default: cur_char = dec_char;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         byte_idx  <= '0;
         snapshot  <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == ST_IDLE) begin
            baud_cnt <= '0;
            if (start) begin
               snapshot <= display_flow;
               byte_idx <= '0;
               bit_idx  <= '0;
               tx       <= 1'b0;
               busy     <= 1'b1;
               state    <= ST_START;
            end
         end else if (baud_cnt != BAUD_LAST) begin
            baud_cnt <= baud_cnt + 1'b1;
         end else begin
            baud_cnt <= '0;
            case (state)
               ST_START: begin
                  // Character is latched at the end of the start bit; bit 0
                  // goes straight to the line, the rest wait in shift_reg.
                  tx        <= cur_char[0];
                  shift_reg <= {1'b0, cur_char[7:1]};
                  bit_idx   <= '0;
                  state     <= ST_DATA;
               end
               ST_DATA: begin
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     tx        <= shift_reg[0];
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     bit_idx   <= bit_idx + 3'd1;
                  end
               end
               ST_STOP: begin
                  if (byte_idx == LAST_BYTE) begin
                     byte_idx <= '0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     tx       <= 1'b0;
                     state    <= ST_START;
                  end
               end
               default: begin
                  tx    <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_flow_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flow_uart_tx
//  Purpose  : Self-checking bench for flow_uart_tx. Two instances (with and
//             without CR/LF) at BAUD_DIV=8; line waveform, busy/done timing
//             and decoded characters are compared with a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flow_uart_tx;

   localparam int DIV    = 8;
   localparam int FRAME  = 10 * DIV;
   localparam int MAXLEN = 8 * FRAME + 4;

   // Hex digit segment codes, index = digit value
   localparam logic [7:0] SEG_TAB [16] = '{
      8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
      8'h01, 8'h19, 8'h11, 8'hC1, 8'hE5, 8'h85, 8'h61, 8'h71};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_c = 1'b0, start_n = 1'b0;
   logic [47:0] flow_c = '0, flow_n = '0;
   logic        tx_c, busy_c, done_c;
   logic        tx_n, busy_n, done_n;

   int n_tests = 0;
   int n_fail  = 0;

   logic s_tx   [MAXLEN];
   logic s_busy [MAXLEN];
   logic s_done [MAXLEN];

   always #5 clk = ~clk;

   flow_uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .SEND_CRLF(1'b1)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .display_flow(flow_c),
      .tx(tx_c), .busy(busy_c), .done(done_c));

   flow_uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .SEND_CRLF(1'b0)) dut_n (
      .clk(clk), .rst(rst), .start(start_n), .display_flow(flow_n),
      .tx(tx_n), .busy(busy_n), .done(done_n));

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] model_char(input logic [7:0] seg);
      if (seg == 8'hFF) return 8'h20;
      for (int i = 0; i < 16; i++)
         if (SEG_TAB[i] == seg)
            return (i < 10) ? 8'(8'h30 + i) : 8'(8'h41 + i - 10);
      return 8'h3F;
   endfunction

   // Sends one transmission and checks it. restart_at >= 0 pulses start and
   // scrambles the flow mid-transmission; rst_at >= 0 aborts with reset.
   task automatic run_tx(input logic [47:0] flow, input bit crlf,
                         input int restart_at, input int rst_at, input string tag);
      logic [7:0] exp_b [$];
      int len, wave_err, edge_err, busy_cnt, done_cnt, bad_after;
      logic [7:0] rx;
      logic exp_bit, cur_tx, cur_busy, cur_done;

      for (int i = 0; i < 6; i++) exp_b.push_back(model_char(flow[47-8*i -: 8]));
      if (crlf) begin
         exp_b.push_back(8'h0D);
         exp_b.push_back(8'h0A);
      end
      len = exp_b.size() * FRAME;

      if (crlf) flow_c = flow; else flow_n = flow;
      cur_tx = crlf ? tx_c : tx_n;
      check_val({tag, "_idle_tx"}, 64'(cur_tx), 64'd1);
      if (crlf) start_c = 1'b1; else start_n = 1'b1;
      tick();
      start_c = 1'b0;
      start_n = 1'b0;

      for (int k = 0; k < len + 2; k++) begin
         s_tx[k]   = crlf ? tx_c   : tx_n;
         s_busy[k] = crlf ? busy_c : busy_n;
         s_done[k] = crlf ? done_c : done_n;
         if (k == rst_at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            cur_tx   = crlf ? tx_c   : tx_n;
            cur_busy = crlf ? busy_c : busy_n;
            cur_done = crlf ? done_c : done_n;
            check_val({tag, "_rst_tx"},   64'(cur_tx),   64'd1);
            check_val({tag, "_rst_busy"}, 64'(cur_busy), 64'd0);
            check_val({tag, "_rst_done"}, 64'(cur_done), 64'd0);
            bad_after = 0;
            for (int j = 0; j < 3 * FRAME; j++) begin
               tick();
               cur_tx   = crlf ? tx_c   : tx_n;
               cur_busy = crlf ? busy_c : busy_n;
               cur_done = crlf ? done_c : done_n;
               if (cur_done || cur_busy || !cur_tx) bad_after++;
            end
            check_val({tag, "_rst_quiet"}, 64'(bad_after), 64'd0);
            return;
         end
         if (k == restart_at) begin
            if (crlf) begin start_c = 1'b1; flow_c = ~flow; end
            else      begin start_n = 1'b1; flow_n = ~flow; end
         end
         if (k == restart_at + 1) begin
            start_c = 1'b0;
            start_n = 1'b0;
         end
         tick();
      end

      wave_err = 0;
      edge_err = 0;
      for (int k = 0; k < len; k++) begin
         int f, b;
         f = k / FRAME;
         b = (k % FRAME) / DIV;
         if (b == 0)      exp_bit = 1'b0;
         else if (b == 9) exp_bit = 1'b1;
         else             exp_bit = exp_b[f][b-1];
         if (s_tx[k] !== exp_bit) wave_err++;
         if (k > 0 && s_tx[k] !== s_tx[k-1] && (k % DIV) != 0) edge_err++;
      end
      check_val({tag, "_wave"},  64'(wave_err), 64'd0);
      check_val({tag, "_edges"}, 64'(edge_err), 64'd0);

      for (int f = 0; f < exp_b.size(); f++) begin
         for (int b = 0; b < 8; b++) rx[b] = s_tx[f*FRAME + (b+1)*DIV + DIV/2];
         check_val($sformatf("%s_byte%0d", tag, f), 64'(rx), 64'(exp_b[f]));
      end

      busy_cnt = 0;
      done_cnt = 0;
      for (int k = 0; k < len + 2; k++) begin
         if (s_busy[k]) busy_cnt++;
         if (s_done[k]) done_cnt++;
      end
      check_val({tag, "_busy_len"},  64'(busy_cnt),   64'(len));
      check_val({tag, "_done_cnt"},  64'(done_cnt),   64'd1);
      check_val({tag, "_done_pos"},  64'(s_done[len]), 64'd1);
      check_val({tag, "_busy_fall"}, 64'({s_busy[len-1], s_busy[len]}), 64'b10);
   endtask

   initial begin
      logic [47:0] rflow;
      logic [9:0]  bits;
      logic [7:0]  code;

      repeat (3) tick();
      check_val("reset_tx_c",   64'(tx_c),   64'd1);
      check_val("reset_busy_c", 64'(busy_c), 64'd0);
      check_val("reset_done_c", 64'(done_c), 64'd0);
      check_val("reset_tx_n",   64'(tx_n),   64'd1);
      check_val("reset_busy_n", 64'(busy_n), 64'd0);
      rst = 1'b0;
      repeat (2) tick();

      // Default digits with CR/LF, plus bit order of the first frame ('0')
      run_tx(48'h039F250D9949, 1'b1, -1, -1, "digits");
      for (int b = 0; b < 10; b++) bits[b] = s_tx[b*DIV + DIV/2];
      check_val("lsb_order", 64'(bits), 64'(10'b1001100000));
      check_val("first_cycle_low", 64'(s_tx[0]), 64'd0);

      // Blanks and unknown codes
      run_tx(48'hFFFF11C1E5AA, 1'b1, -1, -1, "blank_unk");

      // Start while busy, flow changed mid-transmission
      run_tx(48'h039F250D9949, 1'b1, 100, -1, "restart");

      // Reset mid-frame during data of byte 2, then a full resend
      run_tx(48'h039F250D9949, 1'b1, -1, 2*FRAME + 3*DIV + 2, "abort");
      run_tx(48'h039F250D9949, 1'b1, -1, -1, "after_abort");

      // Without CR/LF
      run_tx(48'h85617101191F, 1'b0, -1, -1, "no_crlf");

      // Randomised flows on both instances
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 3))
               0, 1:    code = SEG_TAB[$urandom_range(0, 15)];
               2:       code = 8'hFF;
               default: code = 8'($urandom());
            endcase
            rflow[47-8*i -: 8] = code;
         end
         run_tx(rflow, 1'($urandom_range(0, 1)), -1, -1, $sformatf("rand%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
